// File: rtl/pipelined_chunked_add_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : pipelined_chunked_add_if
// Purpose : Operand/result handshake bundle for pipelined_chunked_add.
// Revision: 1.0 - initial release
// ============================================================================
interface pipelined_chunked_add_if #(
    parameter int ADDER_WIDTH = 32,
    parameter int TAG_WIDTH   = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   cin;
    logic                   sub;
    logic [TAG_WIDTH-1:0]   in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDER_WIDTH-1:0] sum;
    logic                   cout;
    logic                   ovf;
    logic [TAG_WIDTH-1:0]   out_tag;

    modport master (
        output in_valid, a, b, cin, sub, in_tag, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, out_tag
    );

    modport slave (
        input  in_valid, a, b, cin, sub, in_tag, out_ready,
        output in_ready, out_valid, sum, cout, ovf, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_chunked_add.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : pipelined_chunked_add
// Purpose : Adder/subtractor that resolves one CW-bit chunk per pipeline stage.
// Revision: 1.0 - initial release
// ============================================================================
module pipelined_chunked_add #(
    parameter int ADDER_WIDTH = 32,
    parameter int NUM_CHUNKS  = 4,
    parameter int TAG_WIDTH   = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    pipelined_chunked_add_if.slave  bus
);
    localparam int CW  = ADDER_WIDTH / NUM_CHUNKS;
    localparam int N   = NUM_CHUNKS;
    localparam int MSB = ADDER_WIDTH - 1;

    if ((ADDER_WIDTH % NUM_CHUNKS) != 0) begin : g_bad_width
        $error("pipelined_chunked_add: ADDER_WIDTH must be a multiple of NUM_CHUNKS");
    end

    // Every stage carries the full operands, the partially built sum and the
    // carry into the next chunk, so a whole operation moves as one slice.
    logic                   valid_q [N];
    logic [ADDER_WIDTH-1:0] a_q     [N];
    logic [ADDER_WIDTH-1:0] b_q     [N];
    logic [ADDER_WIDTH-1:0] s_q     [N];
    logic                   c_q     [N];
    logic [TAG_WIDTH-1:0]   tag_q   [N];

    logic                   valid_d [N];
    logic [ADDER_WIDTH-1:0] a_d     [N];
    logic [ADDER_WIDTH-1:0] b_d     [N];
    logic [ADDER_WIDTH-1:0] s_d     [N];
    logic                   c_d     [N];
    logic [TAG_WIDTH-1:0]   tag_d   [N];

    logic                   advance;
    logic [CW:0]            chunk;

    function automatic logic [CW:0] chunk_add(
        input logic [CW-1:0] x,
        input logic [CW-1:0] y,
        input logic          c
    );
        return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
    endfunction

    assign advance      = !valid_q[N-1] || bus.out_ready;
    assign bus.in_ready = advance && rst_n;

    always_comb begin
        chunk      = '0;
        // Stage 0: operand preparation plus the least significant chunk.
        valid_d[0] = bus.in_valid && bus.in_ready;
        a_d[0]     = bus.a;
        b_d[0]     = bus.sub ? ~bus.b : bus.b;
        tag_d[0]   = bus.in_tag;
        chunk      = chunk_add(bus.a[CW-1:0], b_d[0][CW-1:0], bus.sub | bus.cin);
        s_d[0]     = '0;
        s_d[0][CW-1:0] = chunk[CW-1:0];
        c_d[0]     = chunk[CW];

        for (int k = 1; k < N; k++) begin
            valid_d[k] = valid_q[k-1];
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            tag_d[k]   = tag_q[k-1];
            chunk      = chunk_add(a_q[k-1][k*CW +: CW], b_q[k-1][k*CW +: CW], c_q[k-1]);
            s_d[k]     = s_q[k-1];
            s_d[k][k*CW +: CW] = chunk[CW-1:0];
            c_d[k]     = chunk[CW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                s_q[k]     <= '0;
                c_q[k]     <= 1'b0;
                tag_q[k]   <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < N; k++) begin
                valid_q[k] <= valid_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                s_q[k]     <= s_d[k];
                c_q[k]     <= c_d[k];
                tag_q[k]   <= tag_d[k];
            end
        end
    end

    assign bus.out_valid = valid_q[N-1];
    assign bus.sum       = s_q[N-1];
    assign bus.cout      = c_q[N-1];
    assign bus.out_tag   = tag_q[N-1];
    // b_q already holds the inverted operand for subtracts.
    assign bus.ovf       = (a_q[N-1][MSB] == b_q[N-1][MSB]) &&
                           (s_q[N-1][MSB] != a_q[N-1][MSB]);
endmodule
`default_nettype wire
